cpu_controller: RTL and testbench

//   Sequencer/decoder for the VeriRISC CPU. An 8-phase counter steps each instruction through fetch and execute.
//   The 3-bit opcode from the instruction register and the ALU's a_is_zero flag are decoded into the control strobes.

---
 rtl/cpu_controller.sv | 168 ++++++++++++++++
 tb/tb_cpu_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//   Sequencer/decoder for the VeriRISC CPU. An 8-phase counter steps each
//   instruction through fetch and execute. The IR opcode and the ALU's
//   a_is_zero flag are decoded into the strobes that drive the address mux,
//   memory, IR, PC and AC.
//
// Parameters
//   ZERO_REG  1: a_is_zero is captured at the end of OP_FETCH and that copy is
//                used in ALU_OP; 0: the live flag is used.
//
// Ports
//   clk     in   clock, all state updates on the rising edge
//   rst     in   synchronous reset, active-high
//   run     in   1: phase advances this cycle; 0: stall, everything held
//   opcode  in   [2:0] IR opcode (HLT SKZ ADD AND XOR LDA STO JMP)
//   zero    in   ALU a_is_zero
//   phase   out  [2:0] current phase
//   sel     out  address mux: 1 = PC, 0 = IR operand
//   rd      out  memory read enable
//   ld_ir   out  load IR from data bus
//   inc_pc  out  increment PC
//   ld_pc   out  load PC from IR operand
//   ld_ac   out  load AC from alu_out
//   data_e  out  drive AC onto data bus
//   wr      out  memory write strobe
//   halt    out  CPU halted (sticky until reset)
// -----------------------------------------------------------------------------
module cpu_controller #(
   parameter int unsigned ZERO_REG = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic [2:0] phase,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       data_e,
   output logic       wr,
   output logic       halt
);

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   phase_t  phase_q, phase_n;
   logic    halted_q, halted_n;
   logic    zero_q, zero_n;
   opcode_t op;
   logic    aluop;
   logic    zero_eff;

   assign op       = opcode_t'(opcode);
   assign aluop    = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   assign zero_eff = (ZERO_REG != 0) ? zero_q : zero;
   assign phase    = phase_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         phase_q  <= phase_n;
         halted_q <= halted_n;
         zero_q   <= zero_n;
      end
   end

   // Next-state logic
   always_comb begin
      phase_n  = phase_q;
      halted_n = halted_q;
      zero_n   = zero_q;
      if (run && !halted_q) begin
         if (phase_q == OP_FETCH) begin
            zero_n = zero;
         end
         // HLT parks the sequencer in OP_ADDR instead of advancing
         if ((phase_q == OP_ADDR) && (op == HLT)) begin
            halted_n = 1'b1;
         end else begin
            phase_n = phase_t'(phase_q + 3'd1);
         end
      end
   end

   // Output decode
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      data_e = 1'b0;
      wr     = 1'b0;
      halt   = 1'b0;
      if (halted_q) begin
         halt = 1'b1;
      end else begin
         unique case (phase_q)
            INST_ADDR: begin
               sel = 1'b1;
            end
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = (op != HLT);
               halt   = (op == HLT);
            end
            OP_FETCH: begin
               rd = aluop;
            end
            ALU_OP: begin
               rd     = aluop;
               // second increment of a taken SKZ skips one instruction
               inc_pc = (op == SKZ) && zero_eff;
               ld_pc  = (op == JMP);
               data_e = (op == STO);
            end
            STORE: begin
               rd     = aluop;
               ld_ac  = aluop;
               ld_pc  = (op == JMP);
               wr     = (op == STO);
               data_e = (op == STO);
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

   logic       clk = 1'b0;
   logic       rst, run, zero;
   logic [2:0] opcode;
   logic [2:0] phase;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;

   always #5 clk = ~clk;

   cpu_controller #(.ZERO_REG(1)) dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .opcode (opcode),
      .zero   (zero),
      .phase  (phase),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .ld_ac  (ld_ac),
      .data_e (data_e),
      .wr     (wr),
      .halt   (halt)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state: instruction step number, halted flag, sampled zero
   int m_phase;
   bit m_halted;
   bit m_zq;

   // Output vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt}
   function automatic logic [8:0] model_out(input logic [2:0] op, input logic z);
      bit aluop, zeff, is_hlt, is_skz, is_sto, is_jmp;
      logic [8:0] o;
      aluop  = (op >= 3'd2) && (op <= 3'd5);
      zeff   = m_zq;
      is_hlt = (op == 3'd0);
      is_skz = (op == 3'd1);
      is_sto = (op == 3'd6);
      is_jmp = (op == 3'd7);
      if (m_halted) return 9'b000000001;
      o[8] = (m_phase <= 3);
      o[7] = (m_phase >= 1 && m_phase <= 3) || (m_phase >= 5 && aluop);
      o[6] = (m_phase == 2 || m_phase == 3);
      o[5] = (m_phase == 4 && !is_hlt) || (m_phase == 6 && is_skz && zeff);
      o[4] = (m_phase >= 6) && is_jmp;
      o[3] = (m_phase == 7) && aluop;
      o[2] = (m_phase >= 6) && is_sto;
      o[1] = (m_phase == 7) && is_sto;
      o[0] = (m_phase == 4) && is_hlt;
      if (z === 1'bx) o = 'x;
      return o;
   endfunction

   function automatic logic [8:0] dut_out();
      return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};
   endfunction

   task automatic compare(input string name, input logic [2:0] gp, input logic [8:0] go,
                          input logic [2:0] ep, input logic [8:0] eo);
      total++;
      if (gp !== ep || go !== eo) begin
         bad++;
         $display("FAIL %s: got phase=%0d out=%b, expected phase=%0d out=%b",
                  name, gp, go, ep, eo);
      end
   endtask

   // One clock cycle: drive inputs, check against the model (and optionally a
   // constant expectation), then advance the model at the rising edge.
   task automatic cycle(input bit r, input bit rn, input logic [2:0] op, input bit z,
                        input string name, input bit has_exp = 1'b0,
                        input logic [2:0] ep = '0, input logic [8:0] eo = '0);
      rst = r; run = rn; opcode = op; zero = z;
      #1;
      compare({name, "/model"}, phase, dut_out(), 3'(m_phase), model_out(op, z));
      if (has_exp) compare({name, "/const"}, phase, dut_out(), ep, eo);
      @(posedge clk);
      if (r) begin
         m_phase = 0; m_halted = 1'b0; m_zq = 1'b0;
      end else if (rn && !m_halted) begin
         if (m_phase == 5) m_zq = z;
         if (m_phase == 4 && op == 3'd0) m_halted = 1'b1;
         else m_phase = (m_phase + 1) % 8;
      end
      #1;
   endtask

   typedef struct {
      logic [2:0] op;
      bit         z;
      logic [2:0] ph;
      logic [8:0] out;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [2:0] op, input bit z, input logic [2:0] ph, input logic [8:0] out);
      vec_t v;
      v.op = op; v.z = z; v.ph = ph; v.out = out;
      tbl.push_back(v);
   endtask

   // Fetch phases: opcode before phase 3 is junk and must not matter
   task automatic add_fetch(input logic [2:0] op, input bit z);
      add(3'($urandom_range(0, 7)), z, 3'd0, 9'b100000000);
      add(3'($urandom_range(0, 7)), z, 3'd1, 9'b110000000);
      add(3'($urandom_range(0, 7)), z, 3'd2, 9'b111000000);
      add(op, z, 3'd3, 9'b111000000);
   endtask

   initial begin
      // LDA
      add_fetch(3'd5, 1'b0);
      add(3'd5, 1'b0, 3'd4, 9'b000100000);
      add(3'd5, 1'b0, 3'd5, 9'b010000000);
      add(3'd5, 1'b0, 3'd6, 9'b010000000);
      add(3'd5, 1'b0, 3'd7, 9'b010001000);
      // STO
      add_fetch(3'd6, 1'b0);
      add(3'd6, 1'b0, 3'd4, 9'b000100000);
      add(3'd6, 1'b0, 3'd5, 9'b000000000);
      add(3'd6, 1'b0, 3'd6, 9'b000000100);
      add(3'd6, 1'b0, 3'd7, 9'b000000110);
      // JMP
      add_fetch(3'd7, 1'b0);
      add(3'd7, 1'b0, 3'd4, 9'b000100000);
      add(3'd7, 1'b0, 3'd5, 9'b000000000);
      add(3'd7, 1'b0, 3'd6, 9'b000010000);
      add(3'd7, 1'b0, 3'd7, 9'b000010000);
      // SKZ taken
      add_fetch(3'd1, 1'b1);
      add(3'd1, 1'b1, 3'd4, 9'b000100000);
      add(3'd1, 1'b1, 3'd5, 9'b000000000);
      add(3'd1, 1'b1, 3'd6, 9'b000100000);
      add(3'd1, 1'b1, 3'd7, 9'b000000000);
      // SKZ not taken
      add_fetch(3'd1, 1'b0);
      add(3'd1, 1'b0, 3'd4, 9'b000100000);
      add(3'd1, 1'b0, 3'd5, 9'b000000000);
      add(3'd1, 1'b0, 3'd6, 9'b000000000);
      add(3'd1, 1'b0, 3'd7, 9'b000000000);
      // XOR
      add_fetch(3'd4, 1'b1);
      add(3'd4, 1'b1, 3'd4, 9'b000100000);
      add(3'd4, 1'b1, 3'd5, 9'b010000000);
      add(3'd4, 1'b1, 3'd6, 9'b010000000);
      add(3'd4, 1'b1, 3'd7, 9'b010001000);

      // Reset
      m_phase = 0; m_halted = 1'b0; m_zq = 1'b0;
      rst = 1'b1; run = 1'b1; opcode = 3'd0; zero = 1'b0;
      @(posedge clk); #1;
      cycle(1'b1, 1'b1, 3'd7, 1'b1, "reset_hold", 1'b1, 3'd0, 9'b100000000);

      // Table-driven instruction sweeps
      foreach (tbl[i])
         cycle(1'b0, 1'b1, tbl[i].op, tbl[i].z, $sformatf("tbl%0d", i), 1'b1, tbl[i].ph, tbl[i].out);

      // Registered zero: flag changes after OP_FETCH are ignored
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 3'd1, 1'b1, "zreg_a_fetch");
      cycle(1'b0, 1'b1, 3'd1, 1'b1, "zreg_a_p4");
      cycle(1'b0, 1'b1, 3'd1, 1'b1, "zreg_a_p5");
      cycle(1'b0, 1'b1, 3'd1, 1'b0, "zreg_a_p6", 1'b1, 3'd6, 9'b000100000);
      cycle(1'b0, 1'b1, 3'd1, 1'b0, "zreg_a_p7");
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 3'd1, 1'b0, "zreg_b_fetch");
      cycle(1'b0, 1'b1, 3'd1, 1'b0, "zreg_b_p4");
      cycle(1'b0, 1'b1, 3'd1, 1'b0, "zreg_b_p5");
      cycle(1'b0, 1'b1, 3'd1, 1'b1, "zreg_b_p6", 1'b1, 3'd6, 9'b000000000);
      cycle(1'b0, 1'b1, 3'd1, 1'b1, "zreg_b_p7");

      // HLT: sticky, run ignored, only reset exits
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 3'd0, 1'b0, "hlt_fetch");
      cycle(1'b0, 1'b1, 3'd0, 1'b0, "hlt_p4", 1'b1, 3'd4, 9'b000000001);
      for (int i = 0; i < 20; i++)
         cycle(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               "hlt_hold", 1'b1, 3'd4, 9'b000000001);
      cycle(1'b1, 1'b1, 3'd2, 1'b0, "hlt_rst", 1'b1, 3'd4, 9'b000000001);
      cycle(1'b0, 1'b0, 3'd2, 1'b0, "hlt_after_rst", 1'b1, 3'd0, 9'b100000000);

      // Stall in STORE with ADD: ld_ac extends, phase holds
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 3'd2, 1'b0, "stall_run");
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 3'd2, 1'b0, "stall_p7", 1'b1, 3'd7, 9'b010001000);
      cycle(1'b0, 1'b1, 3'd2, 1'b0, "stall_release", 1'b1, 3'd7, 9'b010001000);
      cycle(1'b0, 1'b0, 3'd2, 1'b0, "stall_wrap", 1'b1, 3'd0, 9'b100000000);

      // Reset in ALU_OP of a STO
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 3'd6, 1'b0, "midrst_run");
      cycle(1'b1, 1'b1, 3'd6, 1'b0, "midrst_p6", 1'b1, 3'd6, 9'b000000100);
      cycle(1'b0, 1'b0, 3'd6, 1'b0, "midrst_after", 1'b1, 3'd0, 9'b100000000);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++)
         cycle(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
